// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between an icache and a
// dcache. It latches the winning request at grant and holds it until a
// one-cycle RELEASE, with a per-grant watchdog that sets a sticky ERROR flag.
module mem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 63
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ERROR
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
    typedef enum logic {REQ_I, REQ_D} req_t;

    state_t              state;
    state_t              state_nx;
    req_t                last_grant;
    logic                op_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata;
    logic                seen_busy;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                error_q;

    logic                i_pend;
    logic                d_pend;
    logic                in_grant;
    logic                done;
    logic                timeout;
    logic                pick_d;

    assign i_pend   = I_READ;
    assign d_pend   = D_READ | D_WRITE;
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);
    // Completion needs a busy phase first so a stale low MEM_BUSYWAIT on the
    // first grant cycle is not mistaken for a finished access.
    assign done     = in_grant && seen_busy && !MEM_BUSYWAIT;
    // Counter holds the number of completed grant cycles; the watchdog fires
    // on the cycle whose increment would reach MAX_WAIT, so a grant lasts at
    // most MAX_WAIT cycles and a real completion wins a same-cycle tie.
    assign timeout  = in_grant && !done &&
                      ((wait_cnt + 1'b1) == WAIT_W'(MAX_WAIT));
    // dcache wins when alone or when icache was served last.
    assign pick_d   = d_pend && (!i_pend || (last_grant == REQ_I));

    // State register; reset aborts any grant straight to IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state selection: round-robin in IDLE, hold grant until done/timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (pick_d)      state_nx = GRANT_D;
                else if (i_pend) state_nx = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (done || timeout) state_nx = RELEASE;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latching at grant, busy tracking, watchdog and read-data capture.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant <= REQ_I;
            op_write   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata      <= '0;
            seen_busy  <= 1'b0;
            wait_cnt   <= '0;
            error_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (state_nx == GRANT_D) begin
                op_write   <= D_WRITE;
                lat_addr   <= D_ADDRESS;
                lat_wdata  <= D_WRITEDATA;
                last_grant <= REQ_D;
                seen_busy  <= 1'b0;
                wait_cnt   <= '0;
            end else if (state_nx == GRANT_I) begin
                op_write   <= 1'b0;
                lat_addr   <= I_ADDRESS;
                lat_wdata  <= '0;
                last_grant <= REQ_I;
                seen_busy  <= 1'b0;
                wait_cnt   <= '0;
            end
        end else if (in_grant) begin
            if (done) begin
                rdata     <= MEM_READDATA;
                seen_busy <= 1'b0;
            end else if (timeout) begin
                rdata     <= '0;
                error_q   <= 1'b1;
                seen_busy <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (MEM_BUSYWAIT) seen_busy <= 1'b1;
            end
        end
    end

    // Memory strobes only in a grant state, driven from the latched request.
    always_comb begin
        MEM_READ      = in_grant && !op_write;
        MEM_WRITE     = in_grant && op_write;
        MEM_ADDRESS   = lat_addr;
        MEM_WRITEDATA = lat_wdata;
    end

    // Requester stalls: high while pending, low only in that requester's RELEASE.
    always_comb begin
        I_BUSYWAIT = i_pend && !((state == RELEASE) && (last_grant == REQ_I));
        D_BUSYWAIT = d_pend && !((state == RELEASE) && (last_grant == REQ_D));
        I_READDATA = rdata;
        D_READDATA = rdata;
        ERROR      = error_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester sequences push the
// expected memory transactions; a negedge monitor checks each grant and
// each requester completion against the queue.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_READ;
    logic [5:0]  I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [5:0]  D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic        ERROR;

    mem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_WAIT(63)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA),
        .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, want, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [0:63];
    logic        stuck;
    logic        mdl_clr;
    int          busy_cycles;
    logic        m_active, m_done, m_wr;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    int          m_cnt;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[5]       <= 32'hDEAD_BEEF;
            m_active     <= 1'b0;
            m_done       <= 1'b0;
            m_cnt        <= 0;
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= '0;
        end else if (mdl_clr) begin
            m_active     <= 1'b0;
            m_done       <= 1'b0;
            m_cnt        <= 0;
            MEM_BUSYWAIT <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_active) begin
            if (!stuck) begin
                if (m_cnt == 0) begin
                    MEM_BUSYWAIT <= 1'b0;
                    m_active     <= 1'b0;
                    m_done       <= 1'b1;
                    if (m_wr) mem[m_addr] <= m_wdata;
                    else      MEM_READDATA <= mem[m_addr];
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (MEM_READ || MEM_WRITE) begin
            m_active     <= 1'b1;
            MEM_BUSYWAIT <= 1'b1;
            m_cnt        <= busy_cycles - 1;
            m_wr         <= MEM_WRITE;
            m_addr       <= MEM_ADDRESS;
            m_wdata      <= MEM_WRITEDATA;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_d;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    logic prev_act = 1'b0;

    task automatic expect_txn(input logic is_d, input logic wr, input logic [5:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
        exp_q.push_back(t);
    endtask

    // Monitor: grant start, strobe stability during grant, and completions.
    always @(negedge CLK) begin
        if (RESET) begin
            if ((MEM_READ || MEM_WRITE) && !prev_act) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_t = exp_q[0];
                    chk("grant_addr", 32'(MEM_ADDRESS), 32'(mon_t.addr));
                    if (mon_t.wr) chk("grant_wdata", MEM_WRITEDATA, mon_t.wdata);
                end
            end
            if ((MEM_READ || MEM_WRITE) && exp_q.size() != 0) begin
                mon_t = exp_q[0];
                chk("grant_op", {30'd0, MEM_WRITE, MEM_READ},
                    mon_t.wr ? 32'd2 : 32'd1);
            end
            if (I_READ && !I_BUSYWAIT) begin
                if (exp_q.size() == 0) chk("i_done_unexpected", 32'd1, 32'd0);
                else begin
                    mon_t = exp_q.pop_front();
                    chk("i_done_order", 32'(mon_t.is_d), 32'd0);
                    chk("i_readdata", I_READDATA, mon_t.rdata);
                end
            end
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                if (exp_q.size() == 0) chk("d_done_unexpected", 32'd1, 32'd0);
                else begin
                    mon_t = exp_q.pop_front();
                    chk("d_done_order", 32'(mon_t.is_d), 32'd1);
                    if (!mon_t.wr) chk("d_readdata", D_READDATA, mon_t.rdata);
                end
            end
        end
        prev_act = MEM_READ || MEM_WRITE;
    end

    // ---------------- requesters ----------------
    task automatic i_access(input logic [5:0] a);
        int n = 0;
        I_READ = 1'b1; I_ADDRESS = a;
        @(negedge CLK);
        while (I_BUSYWAIT && n < 300) begin @(negedge CLK); n++; end
        if (n >= 300) chk("i_wait_bound", 32'd1, 32'd0);
        @(posedge CLK); #1;
        I_READ = 1'b0;
    endtask

    task automatic d_access(input logic wr, input logic rd, input logic [5:0] a,
                            input logic [31:0] wd);
        int n = 0;
        D_WRITE = wr; D_READ = rd; D_ADDRESS = a; D_WRITEDATA = wd;
        @(negedge CLK);
        while (D_BUSYWAIT && n < 300) begin @(negedge CLK); n++; end
        if (n >= 300) chk("d_wait_bound", 32'd1, 32'd0);
        @(posedge CLK); #1;
        D_WRITE = 1'b0; D_READ = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        RESET = 1'b0; I_READ = 1'b0; I_ADDRESS = '0;
        D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
        stuck = 1'b0; mdl_clr = 1'b0; busy_cycles = 5;

        idle(3);
        chk("rst_mem_read",  32'(MEM_READ), 32'd0);
        chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_mem_addr",  32'(MEM_ADDRESS), 32'd0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        chk("rst_i_rdata",   I_READDATA, 32'd0);
        chk("rst_d_rdata",   D_READDATA, 32'd0);
        chk("rst_error",     32'(ERROR), 32'd0);
        chk("rst_busywaits", {30'd0, I_BUSYWAIT, D_BUSYWAIT}, 32'd0);
        RESET = 1'b1;
        idle(1);

        // Tie right after reset: dcache write first, then icache read.
        busy_cycles = 3;
        expect_txn(1'b1, 1'b1, 6'h3F, 32'h1234_5678, 32'h0);
        expect_txn(1'b0, 1'b0, 6'h05, 32'h0, 32'hDEAD_BEEF);
        fork
            d_access(1'b1, 1'b0, 6'h3F, 32'h1234_5678);
            i_access(6'h05);
        join
        idle(2);

        // Lone icache read, 5 busy cycles.
        busy_cycles = 5;
        expect_txn(1'b0, 1'b0, 6'h05, 32'h0, 32'hDEAD_BEEF);
        i_access(6'h05);
        idle(2);

        // Continuous contention: D, I, D, I.
        busy_cycles = 2;
        expect_txn(1'b1, 1'b0, 6'h10, 32'h0, 32'hA500_0010);
        expect_txn(1'b0, 1'b0, 6'h20, 32'h0, 32'hA500_0020);
        expect_txn(1'b1, 1'b0, 6'h11, 32'h0, 32'hA500_0011);
        expect_txn(1'b0, 1'b0, 6'h21, 32'h0, 32'hA500_0021);
        fork
            begin d_access(1'b0, 1'b1, 6'h10, 32'h0); d_access(1'b0, 1'b1, 6'h11, 32'h0); end
            begin i_access(6'h20); i_access(6'h21); end
        join
        idle(2);

        // Read+write together is a write; then read back both written words.
        busy_cycles = 1;
        expect_txn(1'b1, 1'b1, 6'h2A, 32'hCAFE_F00D, 32'h0);
        d_access(1'b1, 1'b1, 6'h2A, 32'hCAFE_F00D);
        expect_txn(1'b1, 1'b0, 6'h2A, 32'h0, 32'hCAFE_F00D);
        d_access(1'b0, 1'b1, 6'h2A, 32'h0);
        expect_txn(1'b1, 1'b0, 6'h3F, 32'h0, 32'h1234_5678);
        d_access(1'b0, 1'b1, 6'h3F, 32'h0);
        idle(2);
        chk("error_clear_before_wd", 32'(ERROR), 32'd0);

        // Watchdog: memory never finishes; grant lasts 63 cycles, data 0.
        stuck = 1'b1;
        expect_txn(1'b0, 1'b0, 6'h07, 32'h0, 32'h0);
        fork
            i_access(6'h07);
            begin
                n = 0;
                @(negedge CLK);
                while (!MEM_READ && n < 20) begin @(negedge CLK); n++; end
                n = 0;
                while (MEM_READ && n < 200) begin @(negedge CLK); n++; end
                chk("wd_grant_cycles", 32'(n), 32'd63);
                chk("wd_error_set", 32'(ERROR), 32'd1);
            end
        join
        stuck = 1'b0; mdl_clr = 1'b1;
        idle(1);
        mdl_clr = 1'b0;
        idle(1);
        busy_cycles = 2;
        expect_txn(1'b0, 1'b0, 6'h05, 32'h0, 32'hDEAD_BEEF);
        i_access(6'h05);
        chk("error_sticky", 32'(ERROR), 32'd1);
        idle(2);

        // Reset in the middle of a dcache write grant.
        busy_cycles = 10;
        expect_txn(1'b1, 1'b1, 6'h01, 32'h55AA_55AA, 32'h0);
        D_WRITE = 1'b1; D_ADDRESS = 6'h01; D_WRITEDATA = 32'h55AA_55AA;
        n = 0;
        @(negedge CLK);
        while (!MEM_WRITE && n < 20) begin @(negedge CLK); n++; end
        chk("mid_grant_write_seen", 32'(MEM_WRITE), 32'd1);
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_async_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_async_mem_addr",  32'(MEM_ADDRESS), 32'd0);
        chk("rst_async_error",     32'(ERROR), 32'd0);
        chk("rst_d_busy_pending",  32'(D_BUSYWAIT), 32'd1);
        exp_q.delete();
        D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
        #1;
        chk("rst_d_busy_idle", 32'(D_BUSYWAIT), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        idle(1);
        chk("post_rst_mem_write", 32'(MEM_WRITE), 32'd0);

        // Tie after reset goes to dcache again; aborted write left no trace.
        busy_cycles = 2;
        expect_txn(1'b1, 1'b0, 6'h01, 32'h0, 32'hA500_0001);
        expect_txn(1'b0, 1'b0, 6'h02, 32'h0, 32'hA500_0002);
        fork
            d_access(1'b0, 1'b1, 6'h01, 32'h0);
            i_access(6'h02);
        join
        idle(2);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
